// File: rtl/led_arbiter_if.sv
// LED arbiter bus: per-source request/pattern in, one-hot grant and LED drive out.
// Combinational wiring only; any source may request at any time and waits for grant.
interface led_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] pat;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      led;
  logic                  busy;

  modport master (output req, pat, input grant, led, busy);
  modport slave  (input req, pat, output grant, led, busy);
endinterface

// File: rtl/led_arbiter.sv
// Round-robin LED owner with minimum hold; grant 1 cycle after req, led 1 cycle after grant.
// Waiting sources stall on req until the owner releases or its hold time expires.
module led_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 12000000
) (
  input  logic          clk,
  input  logic          rst_n,
  led_arbiter_if.slave  bus
);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic          win_vld;
  logic [PW-1:0] win_idx;
  logic [PW:0]   sum;
  logic          owner_req;
  logic          others;

  // Search upward from ptr+1; iterating down lets the nearest candidate win.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = (PW+1)'(ptr_q) + (PW+1)'(k + 1);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (bus.req[sum[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = sum[PW-1:0];
      end
    end
  end

  assign owner_req = |(bus.req & grant_q);
  assign others    = |(bus.req & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    led_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d          = OWN;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = win_idx;
          cnt_d            = CW'(HOLD_CYCLES - 1);
        end
      end
      OWN: begin
        led_d = bus.pat[ptr_q*WIDTH +: WIDTH];
        if (!owner_req && !others) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (!owner_req || (cnt_q == '0 && others)) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = win_idx;
          cnt_d            = CW'(HOLD_CYCLES - 1);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.led   = led_q;
  assign bus.busy  = |grant_q;
endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter: per-cycle expectations queued as stimulus is applied.
module tb_led_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int HOLD = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  typedef struct {
    string          tag;
    logic [NREQ-1:0] g;
    logic [W-1:0]    l;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] el;

  led_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

  led_arbiter #(.NREQ(NREQ), .WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [NREQ-1:0] g, input logic [W-1:0] l);
    logic [NREQ+W:0] obs;
    logic [NREQ+W:0] expv;
    obs  = {bus.grant, bus.led, bus.busy};
    expv = {g, l, (g != '0)};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed grant=%b led=%b busy=%b, expected grant=%b led=%b busy=%b",
             tag, bus.grant, bus.led, bus.busy, g, l, (g != '0));
    end
  endtask

  // Queue what the next edge must produce, clock, then compare the head entry.
  task automatic step(input string tag, input logic [NREQ-1:0] g, input logic [W-1:0] l);
    exp_t e;
    sb.push_back('{tag: tag, g: g, l: l});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk(e.tag, e.g, e.l);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.pat = '0;

    // 1. reset and single requester
    #1;
    chk("rst_async", 4'b0000, 4'b0000);
    step("rst_c1", 4'b0000, 4'b0000);
    step("rst_c2", 4'b0000, 4'b0000);
    step("rst_c3", 4'b0000, 4'b0000);
    rst_n = 1'b1;
    step("idle_after_rst", 4'b0000, 4'b0000);
    bus.req = 4'b0001;
    bus.pat = 16'h000A;
    step("single_grant", 4'b0001, 4'b0000);
    step("single_led", 4'b0001, 4'b1010);
    bus.req = 4'b0000;
    step("single_drop_grant", 4'b0000, 4'b1010);
    step("single_drop_led", 4'b0000, 4'b0000);

    // 2. round-robin fairness from a fresh pointer
    rst_n = 1'b0;
    step("rr_rst", 4'b0000, 4'b0000);
    rst_n = 1'b1;
    bus.pat = 16'h8421;
    bus.req = 4'b1111;
    for (int o = 0; o < NREQ; o++) begin
      for (int c = 0; c < HOLD; c++) begin
        if (c == 0) el = (o == 0) ? 4'b0000 : (4'b0001 << (o - 1));
        else        el = 4'b0001 << o;
        step($sformatf("rr_o%0d_c%0d", o, c), 4'b0001 << o, el);
      end
    end
    step("rr_wrap", 4'b0001, 4'b1000);

    // 3a. hold enforcement against a later competitor
    bus.req = 4'b0000;
    step("h_idle1", 4'b0000, 4'b0001);
    step("h_idle2", 4'b0000, 4'b0000);
    bus.req = 4'b0001;
    step("h_own0", 4'b0001, 4'b0000);
    bus.req = 4'b0101;
    step("h_hold1", 4'b0001, 4'b0001);
    step("h_hold2", 4'b0001, 4'b0001);
    step("h_hold3", 4'b0001, 4'b0001);
    step("h_switch", 4'b0100, 4'b0001);
    step("h_led2", 4'b0100, 4'b0100);

    // 3b. early release goes straight to the waiter
    bus.req = 4'b0000;
    step("e_idle1", 4'b0000, 4'b0100);
    step("e_idle2", 4'b0000, 4'b0000);
    bus.req = 4'b0001;
    step("e_own0", 4'b0001, 4'b0000);
    bus.req = 4'b0101;
    step("e_wait", 4'b0001, 4'b0001);
    bus.req = 4'b0100;
    step("e_release", 4'b0100, 4'b0001);
    step("e_led2", 4'b0100, 4'b0100);

    // 4. sole owner past expiry, then a late competitor
    bus.req = 4'b0010;
    step("sole_c0", 4'b0010, 4'b0100);
    for (int c = 1; c < 20; c++) step($sformatf("sole_c%0d", c), 4'b0010, 4'b0010);
    bus.req = 4'b1010;
    step("sole_compete", 4'b1000, 4'b0010);
    step("sole_led3", 4'b1000, 4'b1000);

    // 5. pattern tracking on owner 1
    bus.req = 4'b0010;
    step("pt_grant1", 4'b0010, 4'b1000);
    step("pt_led1", 4'b0010, 4'b0010);
    bus.pat = 16'hF471;
    step("pt_0111", 4'b0010, 4'b0111);
    bus.pat = 16'h94C1;
    step("pt_1100", 4'b0010, 4'b1100);
    step("pt_other3", 4'b0010, 4'b1100);
    bus.pat = 16'h94CF;
    step("pt_other0", 4'b0010, 4'b1100);

    // 6. asynchronous reset while owner 2 holds the LEDs
    bus.req = 4'b0100;
    step("mr_grant2", 4'b0100, 4'b1100);
    step("mr_led2", 4'b0100, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async", 4'b0000, 4'b0000);
    bus.req = 4'b1111;
    step("mr_held", 4'b0000, 4'b0000);
    rst_n = 1'b1;
    step("mr_first0", 4'b0001, 4'b0000);
    step("mr_led0", 4'b0001, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Round-robin arbiter that shares the board's 4 LEDs between up to NREQ pattern sources, e.g. switch mirror, blinker, counter, heartbeat.
- Sits between the pattern generators and the LED pins: exactly one source drives `led` at a time, and it keeps the LEDs for at least a minimum hold time.
- Gives the top level a single owner of the LED resource instead of ad-hoc muxing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, LED/pattern width in bits.
- HOLD_CYCLES, 12000000, minimum cycles an owner keeps the LEDs when others are waiting (1 s at 12 MHz). Must be >= 1. Benches use 4.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  request per source; level, held while the source wants the LEDs.
- pat  input  NREQ*WIDTH  patterns; source i occupies bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  one-hot current owner, or all zero.
- led  output  WIDTH  LED drive, registered.
- busy  output  1  high while any grant is active.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0 or after rst_n assertion: grant=0, led=0, busy=0, state=IDLE, hold counter=0, round-robin pointer=NREQ-1, so the first search starts at index 0. Reset mid-ownership drops the grant immediately (asynchronously).
- States: IDLE, OWN.
- IDLE:
  - led is registered 0.
  - If any req bit is high at edge T, then at edge T+1: state=OWN, grant=one-hot of the winner, busy=1, counter=HOLD_CYCLES-1, pointer=winner.
  - Winner is the first set req bit searching upward (with wrap) from pointer+1.
- OWN:
  - Each edge, led <= pat slice of the current owner. led shows the owner's pattern starting 1 cycle after grant rises and tracks pattern changes with 1-cycle latency.
  - Counter decrements once per cycle while >0. expired = (counter==0).
- Owner releases (req[owner]=0 at edge T):
  - If no other req, then at T+1: grant=0, busy=0, state=IDLE. led becomes 0 at T+2.
  - If other reqs are pending, then at T+1: grant moves directly to the next round-robin winner, counter is reloaded, and there is no idle cycle.
  - Release is honoured regardless of the hold counter.
- Hold expiry: if expired, req[owner]=1, and another req is pending, then at the next edge grant moves to the next round-robin winner after the owner. The counter is reloaded.
- If expired and only the owner requests: keep the grant and stay at counter=0. A later competing req causes a switch on the first edge it is sampled.
- Before expiry, competing requests wait. The grant never changes while the owner requests and counter>0.
- Invariants: grant is always one-hot or zero; busy == |grant; no requester is granted on a cycle its req was sampled low.
- A req pulse shorter than one clock can be missed; this is legal.
- Fairness: with all requesters continuously requesting, grants cycle 0,1,2,...,NREQ-1,0, each holding exactly HOLD_CYCLES cycles.
- Width rules:
  - Counter width is $clog2(HOLD_CYCLES)+1.
  - Pointer width is $clog2(NREQ), with a minimum of 1.
  - The modulo wrap is done on index, not by overflow.

Test Plan (NREQ=4, WIDTH=4, HOLD_CYCLES=4):
1. Reset and single requester: rst_n=0 for 3 cycles, then release. Assert req=0001, pat0=4'b1010 → grant=0001 one edge later, led=1010 one edge after that, busy=1. Drop req → grant=0000 next edge, led=0000 the edge after.
2. Round-robin fairness: req=1111 held, pats 1,2,4,8 → grant sequence 0001,0010,0100,1000,0001, each exactly 4 cycles. led follows 0001,0010,0100,1000 delayed by 1 cycle.
3. Hold enforcement and early release:
   - Owner 0 granted; req[2] rises one cycle later → grant stays 0001 for 4 cycles, then becomes 0100.
   - Repeat with req[0] dropped in cycle 2 → grant becomes 0100 on the next edge with no IDLE gap.
4. Sole owner past expiry: req=0010 for 20 cycles → grant stays 0010 throughout. Raise req[3] at cycle 20 → grant=1000 at the next edge.
5. Pattern tracking: while owner 1 is granted, change pat1 to 0111 then 1100 on consecutive cycles → led shows 0111 then 1100, each one cycle later. Changes to non-owner pats never appear on led.
6. Reset mid-operation: during grant=0100, pull rst_n low between clock edges → grant=0000, led=0000, busy=0 immediately. Release reset with req=1111 → first grant=0001.
